// File: rtl/mem_4_port_scheduler_if.sv
// Requester, memory-port and response bundle for the 4-port memory scheduler.
// The scheduler sits on the slave side; requesters and the memory sit on the master side.
interface mem_4_port_scheduler_if #(
    parameter int NUM_REQ  = 8,
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4
);
    logic [NUM_REQ-1:0]          req_val;
    logic [NUM_REQ-1:0]          req_rdy;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]    req_wdata;
    logic [3:0]                  mem_en;
    logic [3:0]                  mem_wen;
    logic [4*IDX_SIZE-1:0]       mem_addr;
    logic [4*WIDTH-1:0]          mem_wdata;
    logic [4*WIDTH-1:0]          mem_rdata;
    logic [NUM_REQ-1:0]          resp_val;
    logic [NUM_REQ*WIDTH-1:0]    resp_data;

    modport master (
        output req_val, req_write, req_addr, req_wdata, mem_rdata,
        input  req_rdy, mem_en, mem_wen, mem_addr, mem_wdata, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_write, req_addr, req_wdata, mem_rdata,
        output req_rdy, mem_en, mem_wen, mem_addr, mem_wdata, resp_val, resp_data
    );
endinterface

// File: rtl/mem_4_port_scheduler.sv
// Round-robin scheduler mapping up to four requests per cycle onto a 4-port fixed-latency
// memory, blocking address hazards and returning each response exactly LATENCY cycles later.
module mem_4_port_scheduler #(
    parameter int NUM_REQ  = 8,
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4,
    parameter int LATENCY  = 5,
    parameter int REQ_ID_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_4_port_scheduler_if.slave bus
);
    localparam int NPORT = 4;
    localparam int SUM_W = REQ_ID_W + 1;

    logic [LATENCY-1:0]  vld_q  [NPORT];
    logic [LATENCY-1:0]  vld_d  [NPORT];
    logic [LATENCY-1:0]  wr_q   [NPORT];
    logic [LATENCY-1:0]  wr_d   [NPORT];
    logic [REQ_ID_W-1:0] id_q   [NPORT][LATENCY];
    logic [REQ_ID_W-1:0] id_d   [NPORT][LATENCY];
    logic [IDX_SIZE-1:0] addr_q [NPORT][LATENCY];
    logic [IDX_SIZE-1:0] addr_d [NPORT][LATENCY];
    logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_SIZE-1:0] r_addr  [NUM_REQ];
    logic [WIDTH-1:0]    r_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]  blocked;
    logic [NUM_REQ-1:0]  gnt;
    logic [NPORT-1:0]    port_vld;
    logic [NPORT-1:0]    port_wr;
    logic [REQ_ID_W-1:0] port_id    [NPORT];
    logic [IDX_SIZE-1:0] port_addr  [NPORT];
    logic [WIDTH-1:0]    port_wdata [NPORT];
    logic [2:0]          n_sel;
    logic [SUM_W-1:0]    scan_sum;
    logic [REQ_ID_W-1:0] scan_id;
    logic [REQ_ID_W-1:0] last_idx;
    logic                conflict;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i]  = bus.req_addr[i*IDX_SIZE +: IDX_SIZE];
            r_wdata[i] = bus.req_wdata[i*WIDTH +: WIDTH];
        end
    end

    // Stages 1..LATENCY-1 hold writes not yet committed; any access to their address waits.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < NPORT; k++)
                for (int s = 0; s < LATENCY - 1; s++)
                    if (vld_q[k][s] && wr_q[k][s] && addr_q[k][s] == r_addr[i])
                        blocked[i] = 1'b1;
    end

    always_comb begin
        gnt      = '0;
        port_vld = '0;
        port_wr  = '0;
        n_sel    = '0;
        last_idx = rr_ptr_q;
        scan_sum = '0;
        scan_id  = '0;
        conflict = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            port_id[k]    = '0;
            port_addr[k]  = '0;
            port_wdata[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(j);
            if (scan_sum >= SUM_W'(NUM_REQ))
                scan_sum = scan_sum - SUM_W'(NUM_REQ);
            scan_id  = scan_sum[REQ_ID_W-1:0];
            conflict = 1'b0;
            // Same-address pairs this cycle are only allowed when both are reads.
            for (int p = 0; p < NPORT; p++)
                if (port_vld[p] && port_addr[p] == r_addr[scan_id] &&
                    (port_wr[p] || bus.req_write[scan_id]))
                    conflict = 1'b1;
            if (!reset && bus.req_val[scan_id] && !blocked[scan_id] && !conflict &&
                n_sel < 3'd4) begin
                gnt[scan_id]            = 1'b1;
                port_vld[n_sel[1:0]]    = 1'b1;
                port_wr[n_sel[1:0]]     = bus.req_write[scan_id];
                port_id[n_sel[1:0]]     = scan_id;
                port_addr[n_sel[1:0]]   = r_addr[scan_id];
                port_wdata[n_sel[1:0]]  = r_wdata[scan_id];
                last_idx                = scan_id;
                n_sel                   = n_sel + 3'd1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (n_sel != 3'd0)
            rr_ptr_d = (last_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end

    always_comb begin
        bus.req_rdy   = gnt;
        bus.mem_en    = '0;
        bus.mem_wen   = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        for (int k = 0; k < NPORT; k++) begin
            bus.mem_en[k]                        = port_vld[k];
            bus.mem_wen[k]                       = port_vld[k] & port_wr[k];
            bus.mem_addr[k*IDX_SIZE +: IDX_SIZE] = port_addr[k];
            bus.mem_wdata[k*WIDTH +: WIDTH]      = port_wdata[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NPORT; k++) begin
            vld_d[k][0]  = port_vld[k];
            wr_d[k][0]   = port_wr[k];
            id_d[k][0]   = port_id[k];
            addr_d[k][0] = port_addr[k];
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[k][s]  = vld_q[k][s-1];
                wr_d[k][s]   = wr_q[k][s-1];
                id_d[k][s]   = id_q[k][s-1];
                addr_d[k][s] = addr_q[k][s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            for (int k = 0; k < NPORT; k++)
                vld_q[k] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < NPORT; k++)
                vld_q[k] <= vld_d[k];
        end
        wr_q   <= wr_d;
        id_q   <= id_d;
        addr_q <= addr_d;
    end

    // Final stage lines up with the memory's read data for that port.
    always_comb begin
        bus.resp_val  = '0;
        bus.resp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NPORT; k++) begin
                if (!reset && vld_q[k][LATENCY-1] && id_q[k][LATENCY-1] == REQ_ID_W'(i)) begin
                    bus.resp_val[i] = 1'b1;
                    if (!wr_q[k][LATENCY-1])
                        bus.resp_data[i*WIDTH +: WIDTH] = bus.mem_rdata[k*WIDTH +: WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_4_port_scheduler.sv
// Bench for mem_4_port_scheduler: a fixed-latency memory model, a queue-based reference
// scheduler, table vectors, directed hazard/reset sequences and randomized traffic.
module tb_mem_4_port_scheduler;
    localparam int N = 8;
    localparam int W = 32;
    localparam int A = 4;
    localparam int L = 5;

    localparam logic [31:0] INIT_MEM [16] = '{
        32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003,
        32'h11110004, 32'hDEADBEEF, 32'h11110006, 32'h11110007,
        32'h11110008, 32'h11110009, 32'h1111000A, 32'h1111000B,
        32'h1111000C, 32'h1111000D, 32'h1111000E, 32'h1111000F};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_4_port_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .IDX_SIZE(A)) bus ();

    mem_4_port_scheduler #(
        .NUM_REQ(N), .WIDTH(W), .IDX_SIZE(A), .LATENCY(L), .REQ_ID_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Memory: an access issued in cycle c completes in cycle c+L; reads see the array
    // before that cycle's write commits.
    logic [31:0]  mem_arr [16] = INIT_MEM;
    logic [3:0]   dl_en   [L]  = '{default: '0};
    logic [3:0]   dl_wen  [L]  = '{default: '0};
    logic [15:0]  dl_addr [L]  = '{default: '0};
    logic [127:0] dl_wd   [L]  = '{default: '0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (dl_en[L-1][k] && dl_wen[L-1][k])
                mem_arr[dl_addr[L-1][k*4 +: 4]] <= dl_wd[L-1][k*32 +: 32];
        dl_en[0]   <= bus.mem_en;
        dl_wen[0]  <= bus.mem_wen;
        dl_addr[0] <= bus.mem_addr;
        dl_wd[0]   <= bus.mem_wdata;
        for (int s = 1; s < L; s++) begin
            dl_en[s]   <= dl_en[s-1];
            dl_wen[s]  <= dl_wen[s-1];
            dl_addr[s] <= dl_addr[s-1];
            dl_wd[s]   <= dl_wd[s-1];
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            if (dl_en[L-1][k] && !dl_wen[L-1][k])
                bus.mem_rdata[k*32 +: 32] = mem_arr[dl_addr[L-1][k*4 +: 4]];
    end

    // Reference scheduler state: list of outstanding operations with their issue cycle.
    typedef struct {
        int          issue;
        int          id;
        bit          wr;
        int          addr;
        logic [31:0] data;
        bit          dead;
    } op_t;

    op_t         q[$];
    int          ref_ptr;
    int          cyc;
    logic [31:0] ref_mem [16];
    int          g_n, g_last;
    int          g_id [4];
    int          g_a  [4];
    bit          g_w  [4];
    logic [31:0] g_d  [4];

    logic [7:0]   e_rdy, e_rval;
    logic [3:0]   e_en, e_wen;
    logic [15:0]  e_addr;
    logic [127:0] e_wdata, wmask;
    logic [255:0] e_rdata;

    logic [7:0]   s_rdy, s_rval;
    logic [3:0]   s_en, s_wen;
    logic [15:0]  s_addr;
    logic [255:0] s_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic ref_eval();
        int  i, a;
        bit  ok, w;
        e_rdy = '0; e_rval = '0; e_en = '0; e_wen = '0; e_addr = '0;
        e_wdata = '0; wmask = '0; e_rdata = '0;
        g_n = 0; g_last = 0;
        if (reset) begin
            foreach (q[m]) q[m].dead = 1'b1;
        end else begin
            for (int j = 0; j < N; j++) begin
                i  = (ref_ptr + j) % N;
                a  = int'(bus.req_addr[i*A +: A]);
                w  = bus.req_write[i];
                ok = bus.req_val[i] && (g_n < 4);
                foreach (q[m])
                    if (!q[m].dead && q[m].wr && q[m].addr == a && (cyc - q[m].issue) < L)
                        ok = 1'b0;
                for (int p = 0; p < g_n; p++)
                    if (g_a[p] == a && (g_w[p] || w)) ok = 1'b0;
                if (ok) begin
                    g_id[g_n] = i; g_a[g_n] = a; g_w[g_n] = w;
                    g_d[g_n]  = bus.req_wdata[i*W +: W];
                    e_rdy[i] = 1'b1;
                    e_en[g_n] = 1'b1;
                    e_wen[g_n] = w;
                    e_addr[g_n*4 +: 4] = 4'(a);
                    if (w) begin
                        e_wdata[g_n*32 +: 32] = g_d[g_n];
                        wmask[g_n*32 +: 32]   = 32'hFFFF_FFFF;
                    end
                    g_last = i;
                    g_n++;
                end
            end
        end
        foreach (q[m])
            if (!q[m].dead && q[m].issue == cyc - L) begin
                e_rval[q[m].id] = 1'b1;
                e_rdata[q[m].id*32 +: 32] = q[m].wr ? 32'h0 : ref_mem[q[m].addr];
            end
    endtask

    task automatic ref_update();
        for (int m = q.size() - 1; m >= 0; m--)
            if (q[m].issue <= cyc - L) begin
                if (q[m].wr) ref_mem[q[m].addr] = q[m].data;
                q.delete(m);
            end
        for (int p = 0; p < g_n; p++)
            q.push_back('{cyc, g_id[p], g_w[p], g_a[p], g_d[p], 1'b0});
        if (reset) ref_ptr = 0;
        else if (g_n > 0) ref_ptr = (g_last + 1) % N;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        ref_eval();
        s_rdy = bus.req_rdy; s_en = bus.mem_en; s_wen = bus.mem_wen; s_addr = bus.mem_addr;
        s_rval = bus.resp_val; s_rdata = bus.resp_data;
        chk("req_rdy", s_rdy, e_rdy);
        chk("mem_en", s_en, e_en);
        chk("mem_wen", s_wen, e_wen);
        chk("mem_addr", s_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata & wmask, e_wdata);
        chk("resp_val", s_rval, e_rval);
        chk("resp_data", s_rdata, e_rdata);
        @(posedge clk);
        ref_update();
        #1;
    endtask

    task automatic idle_req();
        bus.req_val = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit wr, input int a, input logic [31:0] d);
        bus.req_val[i]          = 1'b1;
        bus.req_write[i]        = wr;
        bus.req_addr[i*A +: A]  = 4'(a);
        bus.req_wdata[i*W +: W] = d;
    endtask

    task automatic ticks(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    typedef struct {
        logic [7:0]  val;
        logic [7:0]  wr;
        logic [31:0] addr;
        logic [7:0]  exp_rdy;
        logic [3:0]  exp_en;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int blk;
        bit got;

        tbl[0] = '{8'h3F, 8'h00, 32'h76543210, 8'h0F, 4'hF};
        tbl[1] = '{8'h30, 8'h00, 32'h76543210, 8'h30, 4'h3};
        tbl[2] = '{8'hFF, 8'h00, 32'hFEDCBA98, 8'hC3, 4'hF};
        tbl[3] = '{8'h3C, 8'h00, 32'hFEDCBA98, 8'h3C, 4'hF};
        tbl[4] = '{8'h03, 8'h03, 32'h000000AA, 8'h01, 4'h1};
        tbl[5] = '{8'h06, 8'h00, 32'h00000BB0, 8'h06, 4'h3};

        foreach (ref_mem[m]) ref_mem[m] = INIT_MEM[m];
        ref_ptr = 0;
        cyc = 0;
        idle_req();

        // Reset holds everything quiet even with every requester asking.
        reset = 1'b1;
        tick();
        bus.req_val = 8'hFF;
        tick();
        chk("rst_rdy", s_rdy, 8'h00);
        chk("rst_en", s_en, 4'h0);
        chk("rst_rval", s_rval, 8'h00);
        idle_req();
        reset = 1'b0;
        tick();

        // Single read of addr 5 by requester 2.
        set_req(2, 1'b0, 5, 32'h0);
        tick();
        chk("t1_rdy", s_rdy, 8'h04);
        chk("t1_en", s_en, 4'b0001);
        chk("t1_addr0", s_addr[3:0], 4'd5);
        idle_req();
        ticks(4);
        chk("t1_early", s_rval, 8'h00);
        tick();
        chk("t1_rval", s_rval, 8'h04);
        chk("t1_rdata", s_rdata[2*32 +: 32], 32'hDEADBEEF);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Table vectors: rr_ptr starts at 0 here.
        for (int t = 0; t < 6; t++) begin
            bus.req_val   = tbl[t].val;
            bus.req_write = tbl[t].wr;
            bus.req_addr  = tbl[t].addr;
            bus.req_wdata = {8{32'hCAFE0000}};
            tick();
            chk($sformatf("tbl%0d_rdy", t), s_rdy, tbl[t].exp_rdy);
            chk($sformatf("tbl%0d_en", t), s_en, tbl[t].exp_en);
        end
        idle_req();
        ticks(L + 2);

        // Read-read to addr 3 from requesters 4 and 6.
        set_req(4, 1'b0, 3, 32'h0);
        set_req(6, 1'b0, 3, 32'h0);
        tick();
        chk("rr_rdy", s_rdy, 8'h50);
        chk("rr_en", s_en, 4'b0011);
        chk("rr_addr", s_addr[7:0], 8'h33);
        idle_req();
        ticks(4);
        tick();
        chk("rr_rval", s_rval & 8'h50, 8'h50);
        chk("rr_d4", s_rdata[4*32 +: 32], INIT_MEM[3]);
        chk("rr_d6", s_rdata[6*32 +: 32], INIT_MEM[3]);
        ticks(2);

        // Read after in-flight write.
        set_req(1, 1'b1, 7, 32'h1234);
        tick();
        chk("raw_wr_rdy", s_rdy, 8'h02);
        chk("raw_wen", s_wen, 4'b0001);
        idle_req();
        set_req(3, 1'b0, 7, 32'h0);
        blk = 0; got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            if (s_rdy[3]) got = 1'b1; else blk++;
        end
        chk("raw_blocked", 32'(blk), 32'd4);
        idle_req();
        ticks(4);
        tick();
        chk("raw_rval", s_rval[3], 1'b1);
        chk("raw_rdata", s_rdata[3*32 +: 32], 32'h1234);
        ticks(2);

        // Same-cycle write conflict on addr 9.
        set_req(0, 1'b1, 9, 32'hAAAA0000);
        set_req(1, 1'b1, 9, 32'hBBBB1111);
        tick();
        chk("cf_rdy", s_rdy, 8'h01);
        bus.req_val[0] = 1'b0;
        blk = 0; got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            if (s_rdy[1]) got = 1'b1; else blk++;
        end
        chk("cf_blocked", 32'(blk), 32'd4);
        idle_req();
        set_req(2, 1'b0, 9, 32'h0);
        blk = 0; got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            if (s_rdy[2]) got = 1'b1; else blk++;
        end
        chk("cf_rd_blocked", 32'(blk), 32'd4);
        idle_req();
        ticks(4);
        tick();
        chk("cf_rval", s_rval[2], 1'b1);
        chk("cf_rdata", s_rdata[2*32 +: 32], 32'hBBBB1111);
        ticks(2);

        // Reset two cycles after issuing four reads.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, i, 32'h0);
        tick();
        chk("mr_rdy", s_rdy, 8'h0F);
        idle_req();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < L + 1; n++) begin
            tick();
            chk("mr_quiet", s_rval, 8'h00);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i + 8, 32'h0);
        tick();
        chk("mr_ptr0", s_rdy, 8'h0F);
        idle_req();
        ticks(L + 2);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_val[i]          = ($urandom_range(0, 99) < 55);
                bus.req_write[i]        = ($urandom_range(0, 2) == 0);
                bus.req_addr[i*A +: A]  = 4'($urandom_range(0, 5));
                bus.req_wdata[i*W +: W] = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        idle_req();
        ticks(L + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
